// File: rtl/pipe_stage_chain.sv
// Valid/ready register chain with global stall, flush and a bubble-collapsing ready chain.
// Define PIPE_STAGE_CHAIN_SKID_EN to add an input skid register so that in_ready does not depend on out_ready.
module pipe_stage_chain #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 3,
    localparam int unsigned OCC_W = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_n;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_n [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic             take;
    logic [OCC_W-1:0] occ_n;
`ifdef PIPE_STAGE_CHAIN_SKID_EN
    logic             sv_q;
    logic             sv_n;
    logic [WIDTH-1:0] sd_q;
    logic [WIDTH-1:0] sd_n;
`endif

    // Backward ready chain; a scalar carry keeps the vector free of self-reference.
    always_comb begin : ready_chain
        logic carry;
        carry = out_ready & ~stall;
        rdy   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            carry  = (~v_q[k] | carry) & ~stall;
            rdy[k] = carry;
        end
    end

`ifdef PIPE_STAGE_CHAIN_SKID_EN
    assign in_ready = ~sv_q & ~stall & ~flush & ~rst;
`else
    assign in_ready = rdy[0] & ~flush & ~rst;
`endif
    assign take      = in_valid & in_ready;
    assign out_valid = v_q[DEPTH-1] & ~stall & ~rst;
    assign out_data  = d_q[DEPTH-1];

    // Next-state: shift where the downstream stage is ready, empty stages keep their payload.
    always_comb begin : next_state
        v_n = v_q;
        d_n = d_q;
`ifdef PIPE_STAGE_CHAIN_SKID_EN
        sv_n = sv_q;
        sd_n = sd_q;
`endif
        for (int k = 1; k < DEPTH; k++) begin
            if (rdy[k]) begin
                v_n[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    d_n[k] = d_q[k-1];
                end
            end
        end
`ifdef PIPE_STAGE_CHAIN_SKID_EN
        // A parked skid entry always enters stage 0 ahead of new input.
        if (rdy[0]) begin
            if (sv_q) begin
                v_n[0] = 1'b1;
                d_n[0] = sd_q;
                sv_n   = 1'b0;
            end else begin
                v_n[0] = take;
                if (take) begin
                    d_n[0] = in_data;
                end
            end
        end else if (take) begin
            sv_n = 1'b1;
            sd_n = in_data;
        end
        if (flush) begin
            sv_n = 1'b0;
        end
        occ_n = OCC_W'(sv_n);
`else
        if (rdy[0]) begin
            v_n[0] = take;
            if (take) begin
                d_n[0] = in_data;
            end
        end
        occ_n = '0;
`endif
        if (flush) begin
            v_n = '0;
        end
        for (int k = 0; k < DEPTH; k++) begin
            occ_n = occ_n + OCC_W'(v_n[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q       <= '0;
            occupancy <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= '0;
            end
`ifdef PIPE_STAGE_CHAIN_SKID_EN
            sv_q <= 1'b0;
            sd_q <= '0;
`endif
        end else begin
            v_q       <= v_n;
            d_q       <= d_n;
            occupancy <= occ_n;
`ifdef PIPE_STAGE_CHAIN_SKID_EN
            sv_q <= sv_n;
            sd_q <= sd_n;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (DEPTH=3): vector table, directed corner sequences
// and a queue scoreboard that follows every accepted word to the output.
module tb_pipe_stage_chain;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned OCC_W = $clog2(DEPTH + 2);
`ifdef PIPE_STAGE_CHAIN_SKID_EN
    localparam int unsigned FULL_OCC = DEPTH + 1;
`else
    localparam int unsigned FULL_OCC = DEPTH;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] sb_exp;

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] id;
        logic             ordy;
        logic             er;
        logic             ev;
        logic [WIDTH-1:0] ed;
        logic [OCC_W-1:0] eocc;
    } vec_t;
    vec_t tbl [8];

    int  cnt;
    int  vcnt;
    bit  full;
    bit  seen_idle;
    bit  gap;

    pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge; the caller samples at the following falling edge.
    task automatic drive(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                         input logic st, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        @(negedge clk);
    endtask

    // Scoreboard: the handshakes seen here are the ones the next rising edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            check("sb_occupancy", 64'(occupancy), 64'(sb.size()));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_output: got 0x%0h expected no output at %0t", out_data, $time);
                end else begin
                    sb_exp = sb.pop_front();
                    check("sb_data", 64'(out_data), 64'(sb_exp));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
            end
            if (flush) begin
                sb.delete();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 32'h1, 1'b1, 1'b1, 1'b0, 32'h0, OCC_W'(0)};
        tbl[1] = '{1'b1, 32'h2, 1'b1, 1'b1, 1'b0, 32'h0, OCC_W'(1)};
        tbl[2] = '{1'b1, 32'h3, 1'b1, 1'b1, 1'b0, 32'h0, OCC_W'(2)};
        tbl[3] = '{1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 32'h1, OCC_W'(3)};
        tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h2, OCC_W'(3)};
        tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h3, OCC_W'(2)};
        tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h4, OCC_W'(1)};
        tbl[7] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, OCC_W'(0)};

        // Reset with an offered word
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hCAFE_F00D;
        out_ready = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_in_ready", 64'(in_ready), 64'(0));
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_out_data", 64'(out_data), 64'(0));
            check("rst_occupancy", 64'(occupancy), 64'(0));
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;

        // Streaming from the table
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, 1'b0, 1'b0);
            check($sformatf("stream_in_ready[%0d]", i), 64'(in_ready), 64'(tbl[i].er));
            check($sformatf("stream_out_valid[%0d]", i), 64'(out_valid), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                check($sformatf("stream_out_data[%0d]", i), 64'(out_data), 64'(tbl[i].ed));
            end
            check($sformatf("stream_occupancy[%0d]", i), 64'(occupancy), 64'(tbl[i].eocc));
        end

        // Backpressure: fill until in_ready drops, then drain with no gaps
        full = 1'b0;
        for (int i = 0; i < 8 && !full; i++) begin
            drive(1'b1, WIDTH'(32'h10 + i), 1'b0, 1'b0, 1'b0);
            if (!in_ready) full = 1'b1;
        end
        check("bp_in_ready_fell", 64'(full), 64'(1));
        check("bp_occupancy", 64'(occupancy), 64'(FULL_OCC));
        vcnt      = 0;
        seen_idle = 1'b0;
        gap       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (out_valid) begin
                vcnt++;
                if (seen_idle) gap = 1'b1;
            end else begin
                seen_idle = 1'b1;
            end
        end
        check("bp_drain_count", 64'(vcnt), 64'(FULL_OCC));
        check("bp_drain_gap", 64'(gap), 64'(0));

        // Stall holds the full chain
        drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hD, 1'b1, 1'b1, 1'b0);
            check($sformatf("stall_occupancy[%0d]", i), 64'(occupancy), 64'(3));
            check($sformatf("stall_out_valid[%0d]", i), 64'(out_valid), 64'(0));
            check($sformatf("stall_in_ready[%0d]", i), 64'(in_ready), 64'(0));
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("stall_release_valid", 64'(out_valid), 64'(1));
        check("stall_release_data", 64'(out_data), 64'(32'hA));
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("stall_drained", 64'(occupancy), 64'(0));

        // Flush wins over stall and input
        drive(1'b1, 32'h21, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h23, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hEE, 1'b0, 1'b1, 1'b1);
        check("flush_occupancy_before", 64'(occupancy), 64'(3));
        check("flush_in_ready", 64'(in_ready), 64'(0));
        check("flush_out_valid", 64'(out_valid), 64'(0));
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("flush_occupancy_after", 64'(occupancy), 64'(0));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("flush_no_output[%0d]", i), 64'(out_valid), 64'(0));
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end

        // Bubble collapse behind a lone entry
        drive(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
        check("bubble_first_accept", 64'(in_ready), 64'(1));
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h6, 1'b0, 1'b0, 1'b0);
            if (!in_ready) break;
            cnt++;
        end
        check("bubble_accept_count", 64'(cnt), 64'(FULL_OCC - 1));
        check("bubble_occupancy", 64'(occupancy), 64'(FULL_OCC));
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("bubble_out0_valid", 64'(out_valid), 64'(1));
        check("bubble_out0_data", 64'(out_data), 64'(32'h5));
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("bubble_out1_valid", 64'(out_valid), 64'(1));
        check("bubble_out1_data", 64'(out_data), 64'(32'h6));
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional stall and flush
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
            if (occupancy > OCC_W'(FULL_OCC)) begin
                check("rand_occupancy_bound", 64'(occupancy), 64'(FULL_OCC));
            end
        end
        for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("rand_sb_empty", 64'(sb.size()), 64'(0));
        check("rand_final_occupancy", 64'(occupancy), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
